// File: rtl/ila_capture_pkg.sv
// Shared types for the ILA capture core: FSM state encoding and pointer sizing.
// Contents: state_t (IDLE, PRE, WAIT, POST, READ, DONE) and ptr_w(), the
// log2-based width of a circular-buffer pointer for a given depth.
package ila_capture_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4,
    DONE = 3'd5
  } state_t;

  // Pointer width for a power-of-two buffer; wrap comes for free from the width.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ila_capture_ram.sv
// Simple dual-port sample store: one write port, one read port, DEPTH x DW.
// Ports: clk; i_we/i_waddr/i_wdata write side; i_re/i_raddr read request,
// o_rdata registered read data valid one cycle after i_re. No reset on storage.
module ila_capture_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ila_capture_core.sv
// Logic-analyser capture core: registers NUM_CH probe channels, records them in
// a circular buffer, triggers on a masked level/edge match with PRE_TRIG samples
// of history, then streams the DEPTH-sample window out oldest first.
// Ports: clk/rst; probe_in; arm/abort control; trig_mask/trig_value/trig_edge;
// rd_valid/rd_ready/rd_data/rd_last readout stream; busy and sticky triggered.
module ila_capture_core
  import ila_capture_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 8,
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] probe_in,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [NUM_CH*CH_W-1:0] trig_mask,
  input  logic [NUM_CH*CH_W-1:0] trig_value,
  input  logic                   trig_edge,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [NUM_CH*CH_W-1:0] rd_data,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   triggered
);

  localparam int SW     = NUM_CH * CH_W;
  localparam int PW     = ptr_w(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] PRE_OFS    = PW'(PRE_TRIG);
  localparam logic [PW-1:0] PRE_LAST   = PW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [PW-1:0] POST_LAST  = PW'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [PW:0]   ISS_ONE    = (PW+1)'(1);
  localparam logic [PW:0]   ISS_LAST   = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0]   ISS_END    = (PW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [SW-1:0] r_s;
  logic          r_match_q;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_cnt;
  logic [PW:0]   r_issue_cnt;
  logic          r_triggered;

  logic          r_pend;
  logic          r_pend_last;
  logic          r_skid_vld;
  logic [SW-1:0] r_skid_dat;
  logic          r_skid_last;
  logic          r_out_vld;
  logic [SW-1:0] r_out_dat;
  logic          r_out_last;

  logic          w_match;
  logic          w_hit;
  logic          w_start;
  logic          w_trig;
  logic          w_wr_en;
  logic          w_issue;
  logic          w_pop;
  logic          w_load_out;
  logic [1:0]    w_occ;
  logic [SW-1:0] w_ram_q;

  assign w_match    = ((r_s ^ trig_value) & trig_mask) == '0;
  assign w_hit      = trig_edge ? (w_match & ~r_match_q) : w_match;
  assign w_start    = arm & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_trig     = (r_state == WAIT) & w_hit & ~abort;
  assign w_pop      = r_out_vld & rd_ready;
  assign w_load_out = ~r_out_vld | w_pop;

  // Entries held or in flight (output reg, skid, RAM read); the read that is
  // issued now lands two edges later, so at most one may remain after this pop.
  assign w_occ = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_pend) - 2'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (arm) begin
          w_state_nxt = (PRE_TRIG == 0) ? WAIT : PRE;
        end
      end
      PRE: begin
        w_wr_en = 1'b1;
        if (r_cnt == PRE_LAST) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_wr_en = 1'b1;
        if (w_hit) begin
          w_state_nxt = (POST_N == 0) ? READ : POST;
        end
      end
      POST: begin
        w_wr_en = 1'b1;
        if (r_cnt == POST_LAST) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_issue = (r_issue_cnt != ISS_END) && (w_occ <= 2'd1);
        if (w_pop && r_out_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
      w_issue     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= '0;
      r_match_q   <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_issue_cnt <= '0;
      r_triggered <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_dat  <= '0;
      r_skid_last <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_s <= probe_in;

      // Held at 1 while idle so a match already present at arm is not an edge.
      if (abort || (r_state == IDLE) || (r_state == DONE)) begin
        r_match_q <= 1'b1;
      end else begin
        r_match_q <= w_match;
      end

      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_wr_en) begin
        r_cnt <= r_cnt + PTR_ONE;
      end

      if (w_start) begin
        r_wr_ptr    <= '0;
        r_issue_cnt <= '0;
        r_triggered <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        // The trigger sample is written at r_wr_ptr this cycle; the window
        // starts PRE_TRIG slots earlier, modulo the buffer.
        if (w_trig) begin
          r_rd_ptr    <= r_wr_ptr - PRE_OFS;
          r_triggered <= 1'b1;
        end
        if (w_issue) begin
          r_rd_ptr    <= r_rd_ptr + PTR_ONE;
          r_issue_cnt <= r_issue_cnt + ISS_ONE;
        end
      end

      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_last <= (r_issue_cnt == ISS_LAST);
      end

      // Output register plus one skid entry; the skid always holds the older
      // sample, so it refills the output before fresh RAM data does.
      if (w_load_out) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_dat   <= r_skid_dat;
          r_out_last  <= r_skid_last;
          r_skid_vld  <= r_pend;
          r_skid_dat  <= w_ram_q;
          r_skid_last <= r_pend_last;
        end else if (r_pend) begin
          r_out_vld  <= 1'b1;
          r_out_dat  <= w_ram_q;
          r_out_last <= r_pend_last;
        end else begin
          r_out_vld  <= 1'b0;
          r_out_last <= 1'b0;
        end
      end else if (r_pend) begin
        r_skid_vld  <= 1'b1;
        r_skid_dat  <= w_ram_q;
        r_skid_last <= r_pend_last;
      end

      if (abort) begin
        r_triggered <= 1'b0;
        r_pend      <= 1'b0;
        r_skid_vld  <= 1'b0;
        r_out_vld   <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  ila_capture_ram #(
    .DW    (SW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_s),
    .i_re    (w_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  assign rd_valid  = r_out_vld;
  assign rd_data   = r_out_dat;
  assign rd_last   = r_out_last;
  assign triggered = r_triggered;
  assign busy      = (r_state == PRE) | (r_state == WAIT) |
                     (r_state == POST) | (r_state == READ);

endmodule
